// File: rtl/commit_trace.sv
// Retired-instruction trace capture: records {pc, inst, seq} into a first-word-fall-through FIFO,
// flags sequence gaps and dropped records, and drains then halts after an ebreak retires.
module commit_trace #(
    parameter int DEPTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [63:0]               pc_i,
    input  logic [31:0]               inst_i,
    input  logic [63:0]               nr_insts_i,
    output logic                      trace_valid_o,
    input  logic                      trace_ready_i,
    output logic [63:0]               trace_pc_o,
    output logic [31:0]               trace_inst_o,
    output logic [63:0]               trace_seq_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      overflow_o,
    output logic [31:0]               drop_cnt_o,
    output logic                      seq_err_o,
    output logic                      halted_o,
    output logic [1:0]                state_o
);

    // Handshake: a record transfers on a rising edge where trace_valid_o and trace_ready_i are
    // both high; while valid is high and ready is low the trace_* data holds its value.

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);
    localparam logic [31:0] EBREAK   = 32'h0010_0073;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [63:0]     last_nr_q;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q, count_d;
    logic [63:0]     mem_pc   [DEPTH];
    logic [31:0]     mem_inst [DEPTH];
    logic [63:0]     mem_seq  [DEPTH];

    logic retire, seq_bad, full, push_req, push, pop, drop;

    always_comb begin
        retire   = (nr_insts_i != last_nr_q);
        seq_bad  = retire && (nr_insts_i != last_nr_q + 64'd1);
        full     = (count_q == FULL_CNT);
        push_req = retire && (state_q == RUN);
        pop      = trace_valid_o && trace_ready_i;
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        push     = push_req && (!full || pop);
        drop     = push_req && full && !pop;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + ONE_CNT;
        end else if (pop && !push) begin
            count_d = count_q - ONE_CNT;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (push_req && (inst_i == EBREAK)) state_d = DRAIN;
            DRAIN:   if (count_d == '0) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            last_nr_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
            seq_err_o  <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_nr_q <= nr_insts_i;
            count_q   <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (seq_bad) seq_err_o <= 1'b1;
            if (drop) begin
                overflow_o <= 1'b1;
                if (drop_cnt_o != 32'hFFFF_FFFF) drop_cnt_o <= drop_cnt_o + 32'd1;
            end
        end
    end

    // Storage needs no reset; outputs are gated by valid so stale entries never show.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_pc[wr_ptr_q]   <= pc_i;
            mem_inst[wr_ptr_q] <= inst_i;
            mem_seq[wr_ptr_q]  <= nr_insts_i;
        end
    end

    assign trace_valid_o = (count_q != '0) && (state_q != HALTED);
    assign trace_pc_o    = trace_valid_o ? mem_pc[rd_ptr_q]   : '0;
    assign trace_inst_o  = trace_valid_o ? mem_inst[rd_ptr_q] : '0;
    assign trace_seq_o   = trace_valid_o ? mem_seq[rd_ptr_q]  : '0;
    assign count_o       = count_q;
    assign halted_o      = (state_q == HALTED);
    assign state_o       = state_q;

endmodule

// File: doc/commit_trace.md
COMMIT_TRACE -- requirements
Module: commit_trace

Interface
REQ-001 Parameter: DEPTH, 8, trace FIFO entries; power of two, at least 2.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset of all state.
REQ-004 pc_i  input  64  PC of the instruction retiring this cycle.
REQ-005 inst_i  input  32  encoding of the instruction retiring this cycle.
REQ-006 nr_insts_i  input  64  core retired-instruction counter; monotonic, +1 per retire.
REQ-007 trace_valid_o  output  1  FIFO head holds a valid record.
REQ-008 trace_ready_i  input  1  consumer accepts the head record.
REQ-009 trace_pc_o  output  64  head record PC.
REQ-010 trace_inst_o  output  32  head record instruction.
REQ-011 trace_seq_o  output  64  head record sequence number (nr_insts_i value at capture).
REQ-012 count_o  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 overflow_o  output  1  sticky: at least one record dropped.
REQ-014 drop_cnt_o  output  32  dropped-record count, saturating.
REQ-015 seq_err_o  output  1  sticky: nr_insts_i stepped by other than +1 or went backwards.
REQ-016 halted_o  output  1  ebreak retired and FIFO fully drained.

Function
REQ-017 Block SHALL hold last_nr register; retire event = (nr_insts_i != last_nr); last_nr loads nr_insts_i every cycle.
REQ-018 Retire event with nr_insts_i != last_nr+1 (mod 2^64) SHALL set seq_err_o; record still captured normally.
REQ-019 Retire event in RUN state SHALL push {pc_i, inst_i, nr_insts_i}; entry visible at head the cycle after push (registered FIFO, first-word-fall-through).
REQ-020 Pop occurs when trace_valid_o and trace_ready_i are both high at a clock edge; head advances next cycle.
REQ-021 trace_valid_o SHALL equal (count_o != 0) in RUN and DRAIN; trace_* data SHALL remain stable while valid and not ready.
REQ-022 Push and pop in same cycle SHALL leave count unchanged; legal when full (pop frees slot, push accepted).
REQ-023 Push when full without pop SHALL drop the record, set overflow_o, increment drop_cnt_o saturating at 0xFFFFFFFF; FIFO contents unchanged.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH; count_o ranges 0..DEPTH.
REQ-025 State machine: RUN (reset), DRAIN, HALTED.
REQ-026 RUN -> DRAIN when captured retire has inst_i == 0x00100073 (ebreak); the ebreak record SHALL be pushed (or dropped per REQ-023) before the transition.
REQ-027 DRAIN: further retire events ignored (no push, no drop count, seq check still active); pops continue.
REQ-028 DRAIN -> HALTED on the edge where count becomes 0, or on the next edge if already empty on entry.
REQ-029 HALTED: halted_o=1, trace_valid_o=0, no push/pop; state held until reset.
REQ-030 halted_o SHALL be 0 in RUN and DRAIN.

Reset
REQ-031 Reset SHALL asynchronously force: state RUN, last_nr=0, pointers and count_o=0, trace_valid_o=0, overflow_o=0, drop_cnt_o=0, seq_err_o=0, halted_o=0; trace_pc_o/inst_o/seq_o=0.
REQ-032 Reset asserted mid-drain or with full FIFO SHALL discard all entries; first retire after release captured normally.

Verification
REQ-033 nr_insts 0->1->2->3 with pc 0x80000000,+4,+8, ready=1 -> three records, seq 1,2,3, in order, count never above 1.
REQ-034 ready=0, DEPTH+3 consecutive retires -> count_o=DEPTH, overflow_o=1, drop_cnt_o=3; raising ready yields first DEPTH records, seq 1..DEPTH.
REQ-035 Full FIFO, ready=1 and retire same cycle -> record accepted, count stays DEPTH, drop_cnt_o unchanged.
REQ-036 nr_insts 5->7 -> seq_err_o=1, record seq 7 captured; no drop.
REQ-037 Two records queued, ebreak retires, further retires follow, ready=1 -> exactly three records out (last inst 0x00100073), halted_o=1 cycle after count reaches 0, later retires ignored.
REQ-038 Reset asserted in DRAIN with 2 entries -> count_o=0, halted_o=0, state RUN immediately (asynchronous).
